window_skid_pipe: RTL and testbench

- Parametrised pipeline stage between the window-FIFO stage and the pooling stage.
- Carries a CHANNELS x KERNEL_SIZE x KERNEL_SIZE window bundle under a valid/ready handshake, replacing the plain enable-forwarding register.
- A 2-entry skid buffer gives full throughput with registered in_ready, so the pooling stage can apply backpressure.
- Includes flush and saturating performance counters.

---
 rtl/window_skid_pipe.sv | 142 ++++++++++++++
 tb/tb_window_skid_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_skid_pipe.sv
// Valid/ready pipeline stage carrying a CHANNELS x KERNEL_SIZE x KERNEL_SIZE window
// through a 2-entry skid buffer, with flush and saturating delivery/stall counters.
module window_skid_pipe #(
   parameter int KERNEL_SIZE = 2,
   parameter int DATA_WIDTH  = 16,
   parameter int CHANNELS    = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                                                             clk,
   input  logic                                                             rst,
   input  logic                                                             flush,
   input  logic                                                             in_valid,
   output logic                                                             in_ready,
   input  logic [CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] in_window,
   output logic                                                             out_valid,
   input  logic                                                             out_ready,
   output logic [CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] out_window,
   output logic [1:0]                                                       occupancy,
   output logic [CNT_WIDTH-1:0]                                             window_count,
   output logic [CNT_WIDTH-1:0]                                             stall_count
);

   typedef logic [CHANNELS-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] window_t;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               r_state;
   state_t               w_next_state;
   window_t              r_main;
   window_t              r_skid;
   logic                 r_in_ready;
   logic [CNT_WIDTH-1:0] r_window_count;
   logic [CNT_WIDTH-1:0] r_stall_count;
   logic                 w_in_fire;
   logic                 w_out_fire;
   logic                 w_out_valid;
   logic                 w_load_main_in;
   logic                 w_load_main_skid;
   logic                 w_load_skid;

   // r_in_ready is precomputed from the next state; rst only masks it while held
   assign in_ready     = r_in_ready & ~rst;
   assign w_out_valid  = (r_state != ST_EMPTY);
   assign w_in_fire    = in_valid & in_ready;
   assign w_out_fire   = w_out_valid & out_ready;
   assign out_valid    = w_out_valid;
   assign out_window   = r_main;
   assign occupancy    = r_state;
   assign window_count = r_window_count;
   assign stall_count  = r_stall_count;

   // Next-state and data-load selection keyed on occupancy
   always_comb begin
      w_next_state     = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_load_main_in = 1'b1;
               w_next_state   = ST_ONE;
            end else begin
               w_next_state = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
               w_load_skid  = 1'b1;
               w_next_state = ST_FULL;
            end else if (w_out_fire) begin
               w_next_state = ST_EMPTY;
            end else begin
               w_next_state = ST_ONE;
            end
         end
         ST_FULL: begin
            if (w_out_fire) begin
               w_load_main_skid = 1'b1;
               w_next_state     = ST_ONE;
            end else begin
               w_next_state = ST_FULL;
            end
         end
         default: w_next_state = ST_EMPTY;
      endcase
      // Flush discards everything, including a window accepted this cycle
      if (flush) begin
         w_next_state     = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end else begin
         w_next_state = w_next_state;
      end
   end

   // State, registered in_ready and the main/skid data registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
         r_main     <= '0;
         r_skid     <= '0;
      end else begin
         r_state    <= w_next_state;
         r_in_ready <= (w_next_state != ST_FULL);
         if (w_load_main_in) begin
            r_main <= in_window;
         end else if (w_load_main_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= in_window;
         end
      end
   end

   // Saturating delivery and stall counters, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         r_window_count <= '0;
         r_stall_count  <= '0;
      end else begin
         if (w_out_fire && (r_window_count != CNT_MAX)) begin
            r_window_count <= r_window_count + CNT_ONE;
         end
         if (w_out_valid && !out_ready && (r_stall_count != CNT_MAX)) begin
            r_stall_count <= r_stall_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_window_skid_pipe.sv
// Scoreboard bench for window_skid_pipe: a K=2/C=1/CNT_WIDTH=4 instance for the
// handshake, flush, saturation and reset scenarios and a K=3/C=4 instance for data layout.
module tb_window_skid_pipe;
   localparam int K  = 2;
   localparam int DW = 16;
   localparam int C  = 1;
   localparam int CW = 4;
   localparam int MK = 3;
   localparam int MC = 4;

   typedef logic [C-1:0][K-1:0][K-1:0][DW-1:0]     win_t;
   typedef logic [MC-1:0][MK-1:0][MK-1:0][DW-1:0]  mwin_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   win_t          in_window = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   win_t          out_window;
   logic [1:0]    occupancy;
   logic [CW-1:0] window_count;
   logic [CW-1:0] stall_count;

   logic          mc_in_valid = 1'b0;
   logic          mc_in_ready;
   mwin_t         mc_in_window = '0;
   logic          mc_out_valid;
   logic          mc_out_ready = 1'b0;
   mwin_t         mc_out_window;
   logic [1:0]    mc_occupancy;
   logic [15:0]   mc_window_count;
   logic [15:0]   mc_stall_count;

   int            checks = 0;
   int            failures = 0;
   win_t          exp_q[$];
   mwin_t         mexp_q[$];
   win_t          mon_exp;
   mwin_t         mmon_exp;
   logic          last_acc = 1'b0;

   window_skid_pipe #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .CHANNELS(C), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
      .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
      .occupancy(occupancy), .window_count(window_count), .stall_count(stall_count)
   );

   window_skid_pipe #(.KERNEL_SIZE(MK), .DATA_WIDTH(DW), .CHANNELS(MC), .CNT_WIDTH(16)) u_dut_mc (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(mc_in_valid), .in_ready(mc_in_ready), .in_window(mc_in_window),
      .out_valid(mc_out_valid), .out_ready(mc_out_ready), .out_window(mc_out_window),
      .occupancy(mc_occupancy), .window_count(mc_window_count), .stall_count(mc_stall_count)
   );

   always #5 clk = ~clk;

   function automatic win_t mk(input int v);
      win_t w;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++)
            w[0][r][c] = DW'(v);
      return w;
   endfunction

   function automatic mwin_t mkm(input int n);
      mwin_t w;
      for (int ch = 0; ch < MC; ch++)
         for (int r = 0; r < MK; r++)
            for (int c = 0; c < MK; c++)
               w[ch][r][c] = DW'(n * 1000 + ch * 100 + r * 10 + c);
      return w;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every delivered window must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: got %h expected no window", out_window);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out_window !== mon_exp) begin
               failures++;
               $display("FAIL out_data: got %h expected %h", out_window, mon_exp);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && mc_out_valid && mc_out_ready) begin
         checks++;
         if (mexp_q.size() == 0) begin
            failures++;
            $display("FAIL mc_unexpected: got %h expected no window", mc_out_window);
         end else begin
            mmon_exp = mexp_q.pop_front();
            if (mc_out_window !== mmon_exp) begin
               failures++;
               $display("FAIL mc_data: got %h expected %h", mc_out_window, mmon_exp);
            end
         end
      end
   end

   // One clock of the main DUT; acceptances update the expected queue after the edge
   task automatic step();
      logic acc, fl, rs;
      @(negedge clk);
      acc = in_valid && in_ready;
      fl  = flush;
      rs  = rst;
      @(posedge clk);
      #1;
      last_acc = acc && !fl && !rs;
      if (rs || fl) exp_q.delete();
      else if (acc) exp_q.push_back(in_window);
   endtask

   task automatic send(input int v);
      in_valid  = 1'b1;
      in_window = mk(v);
      last_acc  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (last_acc) break;
      end
      check("send_accept", last_acc, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic mc_send(input int n);
      mc_in_valid  = 1'b1;
      mc_in_window = mkm(n);
      @(negedge clk);
      check("mc_in_ready", mc_in_ready, 1'b1);
      if (mc_in_ready) mexp_q.push_back(mc_in_window);
      @(posedge clk);
      #1;
      mc_in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and idle
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready_low", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_occ", occupancy, 2'd0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_wcount", window_count, 4'd0);
      check("rst_scount", stall_count, 4'd0);
      check("rst_window", out_window, 64'd0);

      // Multi-channel layout, streaming then a skid-through-FULL episode
      mc_out_ready = 1'b1;
      for (int n = 0; n < 3; n++) mc_send(n);
      @(posedge clk); #1;
      mc_out_ready = 1'b0;
      mc_send(3);
      mc_send(4);
      check("mc_occ_full", mc_occupancy, 2'd2);
      repeat (2) @(posedge clk);
      #1;
      mc_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mc_wcount", mc_window_count, 64'd5);
      check("mc_scount", mc_stall_count, 64'd3);
      check("mc_drained", mexp_q.size(), 64'd0);

      // Streaming at full throughput, one-cycle latency
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(i);
         check("stream_occ", occupancy, 2'd1);
         check("stream_lat", out_window, mk(i));
      end
      step();
      check("stream_empty", occupancy, 2'd0);
      step();
      check("stream_wcount", window_count, 64'd8);
      check("stream_scount", stall_count, 64'd0);

      // Backpressure: A in main, B in skid, C held upstream
      out_ready = 1'b0;
      send(16'hA);
      check("bp_occ1", occupancy, 2'd1);
      send(16'hB);
      check("bp_occ2", occupancy, 2'd2);
      check("bp_in_ready", in_ready, 1'b0);
      in_valid  = 1'b1;
      in_window = mk(16'hC);
      repeat (3) step();
      check("bp_hold_ready", in_ready, 1'b0);
      check("bp_hold_occ", occupancy, 2'd2);
      check("bp_hold_data", out_window, mk(16'hA));
      check("bp_scount", stall_count, 64'd4);
      out_ready = 1'b1;
      send(16'hC);
      repeat (2) step();
      check("bp_empty", occupancy, 2'd0);
      check("bp_wcount", window_count, 64'd11);

      // Flush while FULL with a same-cycle offer
      out_ready = 1'b0;
      send(16'hD);
      send(16'hE);
      in_valid  = 1'b1;
      in_window = mk(16'hF);
      flush     = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      check("flush_occ", occupancy, 2'd0);
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_in_ready", in_ready, 1'b1);
      check("flush_scount", stall_count, 64'd6);
      out_ready = 1'b1;
      repeat (3) step();
      check("flush_wcount", window_count, 64'd11);
      check("flush_nothing_left", exp_q.size(), 64'd0);

      // Counter saturation at 15
      for (int i = 0; i < 20; i++) send(32 + i);
      repeat (2) step();
      check("sat_wcount", window_count, 64'd15);
      out_ready = 1'b0;
      send(16'h77);
      repeat (20) step();
      check("sat_scount", stall_count, 64'd15);
      check("sat_occ", occupancy, 2'd1);
      out_ready = 1'b1;
      repeat (2) step();
      check("sat_wcount_hold", window_count, 64'd15);

      // Reset while FULL
      out_ready = 1'b0;
      send(16'h55);
      send(16'h66);
      check("mrst_full", occupancy, 2'd2);
      rst = 1'b1;
      step();
      check("mrst_occ", occupancy, 2'd0);
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_in_ready", in_ready, 1'b0);
      check("mrst_wcount", window_count, 64'd0);
      check("mrst_scount", stall_count, 64'd0);
      check("mrst_window", out_window, 64'd0);
      rst = 1'b0;
      #1;
      check("mrst_in_ready_after", in_ready, 1'b1);
      out_ready = 1'b1;
      repeat (3) step();
      check("mrst_no_delivery", window_count, 64'd0);
      check("final_queue_empty", exp_q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
